// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped timer/compare peripheral on the CPU data bus.
//
// Register window: 16 bytes at BASE_ADDR (decode on addr[31:4]).
//   0x0 CTRL    [0] EN, [1] RELOAD, [2] IRQEN, [15:8] PRESC
//   0x4 COUNT   32-bit up-counter, read/write
//   0x8 COMPARE 32-bit compare value, read/write
//   0xC STATUS  [0] MATCH, [1] OVF (sticky, write-1-to-clear in byte lane 0)
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   ce      bus access enable
//   we      1 = write, 0 = read
//   addr    byte address; [3:2] selects register, [1:0] ignored
//   sel     byte-lane write enables
//   data_i  write data
//   data_o  read data, combinational, 0 when not reading this block
//   hit_o   ce & address-in-window, combinational
//   irq_o   registered level interrupt
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        hit_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_COUNT   = 2'd1,
    REG_COMPARE = 2'd2,
    REG_STATUS  = 2'd3
  } reg_e;

  // Implemented CTRL bits; everything else reads 0 and ignores writes.
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;

  logic [31:0] ctrl_q,    ctrl_d;
  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q,   match_d;
  logic        ovf_q,     ovf_d;
  logic [7:0]  pcnt_q,    pcnt_d;
  logic        irq_d;

  logic        ctrl_en, ctrl_reload, ctrl_irqen;
  logic [7:0]  ctrl_presc;
  logic        wr_en, rd_en;
  reg_e        reg_sel;
  logic [31:0] byte_mask;
  logic        tick;
  logic [31:0] count_tick;
  logic        match_set, ovf_set;
  logic        unused_addr_bits;

  assign ctrl_en     = ctrl_q[0];
  assign ctrl_reload = ctrl_q[1];
  assign ctrl_irqen  = ctrl_q[2];
  assign ctrl_presc  = ctrl_q[15:8];

  // Bus decode: everything is combinational so accesses complete in-cycle.
  assign hit_o   = ce & (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_en   = hit_o & we;
  assign rd_en   = hit_o & ~we;
  assign reg_sel = reg_e'(addr[3:2]);
  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      byte_mask[8*i +: 8] = {8{sel[i]}};
    end
  end

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign tick = ctrl_en & (pcnt_q == ctrl_presc);

  // Tick result from the pre-edge COUNT; match has priority over overflow,
  // but when COMPARE is all-ones both flags set on the same tick.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    count_tick = count_q + 32'd1;
    match_set  = 1'b0;
    ovf_set    = 1'b0;
    if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        ovf_set   = (count_q == 32'hFFFF_FFFF) & ~ctrl_reload;
        if (ctrl_reload) count_tick = 32'd0;
      end else if (count_q == 32'hFFFF_FFFF) begin
        ovf_set    = 1'b1;
        count_tick = 32'd0;
      end
    end
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    compare_d = compare_q;
    count_d   = tick ? count_tick : count_q;
    match_d   = match_q;
    ovf_d     = ovf_q;

    if (wr_en) begin
      unique case (reg_sel)
        REG_CTRL:    ctrl_d    = merge_bytes(ctrl_q, data_i, byte_mask) & CTRL_MASK;
        // Written bytes override the tick result; the rest keep it.
        REG_COUNT:   count_d   = merge_bytes(count_d, data_i, byte_mask);
        REG_COMPARE: compare_d = merge_bytes(compare_q, data_i, byte_mask);
        REG_STATUS: begin
          if (sel[0] && data_i[0]) match_d = 1'b0;
          if (sel[0] && data_i[1]) ovf_d   = 1'b0;
        end
        default: ;
      endcase
    end

    // Hardware set is applied after the clear so it wins a collision.
    if (match_set) match_d = 1'b1;
    if (ovf_set)   ovf_d   = 1'b1;

    if (wr_en && reg_sel == REG_CTRL) pcnt_d = 8'd0;
    else if (!ctrl_en || tick)        pcnt_d = 8'd0;
    else                              pcnt_d = pcnt_q + 8'd1;

    irq_d = ctrl_d[2] & (match_d | ovf_d);
  end

  // NOTE: state uses non-blocking assignments and an asynchronous reset
  // so every flop updates together and clears without a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= 32'd0;
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      match_q   <= 1'b0;
      ovf_q     <= 1'b0;
      pcnt_q    <= 8'd0;
      irq_o     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      ovf_q     <= ovf_d;
      pcnt_q    <= pcnt_d;
      irq_o     <= irq_d;
    end
  end

  always_comb begin
    data_o = 32'd0;
    if (rd_en) begin
      unique case (reg_sel)
        REG_CTRL:    data_o = ctrl_q;
        REG_COUNT:   data_o = count_q;
        REG_COMPARE: data_o = compare_q;
        REG_STATUS:  data_o = {30'd0, ovf_q, match_q};
        default:     data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: a table of one-cycle bus vectors
// (each with expected data_o / hit_o / irq_o) followed by a hand-written
// asynchronous-reset sequence.
`timescale 1ns/1ps
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        hit_o;
  logic        irq_o;

  int tests  = 0;
  int failed = 0;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .addr   (addr),
    .sel    (sel),
    .data_i (data_i),
    .data_o (data_o),
    .hit_o  (hit_o),
    .irq_o  (irq_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_d;
    logic        exp_hit;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // In-window read of register at offset off.
  function automatic vec_t rd_v(input logic [3:0] off, input logic [31:0] d, input logic irq);
    vec_t v;
    v.ce = 1'b1; v.we = 1'b0; v.addr = BASE + {28'd0, off}; v.sel = 4'h0; v.wdata = 32'd0;
    v.exp_d = d; v.exp_hit = 1'b1; v.exp_irq = irq;
    return v;
  endfunction

  // In-window write; data_o must read 0 during a write.
  function automatic vec_t wr_v(input logic [3:0] off, input logic [3:0] s,
                                input logic [31:0] d, input logic irq);
    vec_t v;
    v.ce = 1'b1; v.we = 1'b1; v.addr = BASE + {28'd0, off}; v.sel = s; v.wdata = d;
    v.exp_d = 32'd0; v.exp_hit = 1'b1; v.exp_irq = irq;
    return v;
  endfunction

  // Access that must not hit (ce=0 or out of window).
  function automatic vec_t miss_v(input logic c, input logic w, input logic [31:0] a,
                                  input logic [3:0] s, input logic [31:0] d);
    vec_t v;
    v.ce = c; v.we = w; v.addr = a; v.sel = s; v.wdata = d;
    v.exp_d = 32'd0; v.exp_hit = 1'b0; v.exp_irq = 1'b0;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    ce = v.ce; we = v.we; addr = v.addr; sel = v.sel; data_i = v.wdata;
    @(negedge clk);
    check($sformatf("vec%0d data_o", idx), data_o, v.exp_d);
    check($sformatf("vec%0d hit_o", idx), {31'd0, hit_o}, {31'd0, v.exp_hit});
    check($sformatf("vec%0d irq_o", idx), {31'd0, irq_o}, {31'd0, v.exp_irq});
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [3:0] off);
    ce = 1'b1; we = 1'b0; sel = 4'h0; data_i = 32'd0; addr = BASE + {28'd0, off};
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; we = 1'b0; addr = 32'd0; sel = 4'h0; data_i = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset values.
    vecs.push_back(rd_v(4'h0, 32'h0000_0000, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'h0000_0000, 1'b0));
    vecs.push_back(rd_v(4'h8, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(rd_v(4'hC, 32'h0000_0000, 1'b0));

    // Compare match with interrupt, PRESC=0.
    vecs.push_back(wr_v(4'h8, 4'hF, 32'd3, 1'b0));
    vecs.push_back(wr_v(4'h0, 4'hF, 32'h0000_0005, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd0, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd1, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd2, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd3, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd4, 1'b1));
    vecs.push_back(rd_v(4'hC, 32'd1, 1'b1));
    vecs.push_back(wr_v(4'hC, 4'h1, 32'd1, 1'b1));
    vecs.push_back(rd_v(4'hC, 32'd0, 1'b0));

    // Auto-reload with PRESC=2: COUNT steps every 3 cycles.
    vecs.push_back(wr_v(4'h0, 4'hF, 32'd0, 1'b0));
    vecs.push_back(wr_v(4'h4, 4'hF, 32'd0, 1'b0));
    vecs.push_back(wr_v(4'h8, 4'hF, 32'd2, 1'b0));
    vecs.push_back(wr_v(4'h0, 4'hF, 32'h0000_0203, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd0, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd0, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd0, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd1, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd1, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd1, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd2, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd2, 1'b0));
    vecs.push_back(rd_v(4'hC, 32'd0, 1'b0));
    vecs.push_back(rd_v(4'hC, 32'd1, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd0, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd0, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd1, 1'b0));

    // Overflow (COMPARE=0, IRQEN=0).
    vecs.push_back(wr_v(4'h0, 4'hF, 32'd0, 1'b0));
    vecs.push_back(wr_v(4'hC, 4'h1, 32'd3, 1'b0));
    vecs.push_back(wr_v(4'h4, 4'hF, 32'hFFFF_FFFE, 1'b0));
    vecs.push_back(wr_v(4'h8, 4'hF, 32'd0, 1'b0));
    vecs.push_back(wr_v(4'h0, 4'hF, 32'd1, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'hFFFF_FFFE, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(rd_v(4'hC, 32'd2, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd1, 1'b0));   // wrapped to 0, then 0==COMPARE
    vecs.push_back(rd_v(4'hC, 32'd3, 1'b0));

    // Byte lanes, CTRL masking, and decode.
    vecs.push_back(wr_v(4'h0, 4'hF, 32'd0, 1'b0));
    vecs.push_back(wr_v(4'hC, 4'h1, 32'd3, 1'b0));
    vecs.push_back(wr_v(4'h8, 4'hF, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(wr_v(4'h8, 4'b0010, 32'hAABB_CCDD, 1'b0));
    vecs.push_back(rd_v(4'h8, 32'hFFFF_CCFF, 1'b0));
    vecs.push_back(wr_v(4'h0, 4'hF, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(rd_v(4'h0, 32'h0000_FF07, 1'b0));
    vecs.push_back(wr_v(4'h0, 4'hF, 32'd0, 1'b0));
    vecs.push_back(miss_v(1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'h1234_5678));
    vecs.push_back(miss_v(1'b0, 1'b1, BASE + 32'h8, 4'hF, 32'd0));
    vecs.push_back(miss_v(1'b1, 1'b0, BASE + 32'h18, 4'h0, 32'd0));
    vecs.push_back(miss_v(1'b0, 1'b0, BASE + 32'h8, 4'h0, 32'd0));
    vecs.push_back(rd_v(4'h0, 32'd0, 1'b0));
    vecs.push_back(rd_v(4'h8, 32'hFFFF_CCFF, 1'b0));

    // Collisions: COUNT write on a tick edge, partial-lane write on a tick.
    vecs.push_back(wr_v(4'h0, 4'hF, 32'd0, 1'b0));
    vecs.push_back(wr_v(4'hC, 4'h1, 32'd3, 1'b0));
    vecs.push_back(wr_v(4'h8, 4'hF, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(wr_v(4'h4, 4'hF, 32'd0, 1'b0));
    vecs.push_back(wr_v(4'h0, 4'hF, 32'd1, 1'b0));
    vecs.push_back(wr_v(4'h4, 4'hF, 32'd100, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd100, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'd101, 1'b0));
    vecs.push_back(wr_v(4'h4, 4'hF, 32'h0000_01FF, 1'b0));
    vecs.push_back(wr_v(4'h4, 4'h1, 32'h0000_0005, 1'b0));
    vecs.push_back(rd_v(4'h4, 32'h0000_0205, 1'b0));
    // W1C of MATCH on the match edge: the set wins.
    vecs.push_back(wr_v(4'h8, 4'hF, 32'h0000_0210, 1'b0));
    for (int k = 7; k <= 15; k++) begin
      vecs.push_back(rd_v(4'h4, 32'h200 + k, 1'b0));
    end
    vecs.push_back(wr_v(4'hC, 4'h1, 32'd1, 1'b0));
    vecs.push_back(rd_v(4'hC, 32'd1, 1'b0));
    // Enabling IRQEN with MATCH pending raises irq one edge later.
    vecs.push_back(wr_v(4'h0, 4'hF, 32'd5, 1'b0));
    vecs.push_back(rd_v(4'hC, 32'd1, 1'b1));

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset mid-count: state clears with no clock edge.
    @(negedge clk);
    #1 rst = 1'b0;
    bus_read(4'h4); #1 check("async rst COUNT",   data_o, 32'd0);
    bus_read(4'h8); #1 check("async rst COMPARE", data_o, 32'hFFFF_FFFF);
    bus_read(4'h0); #1 check("async rst CTRL",    data_o, 32'd0);
    bus_read(4'hC); #1 check("async rst STATUS",  data_o, 32'd0);
    check("async rst irq_o", {31'd0, irq_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    ce = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus_read(4'h4);
    @(negedge clk);
    check("post rst COUNT idle", data_o, 32'd0);
    bus_read(4'hC);
    #1 check("post rst STATUS idle", data_o, 32'd0);
    check("post rst irq_o", {31'd0, irq_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer/compare peripheral that responds on the CPU data-memory bus, the same bus `cpu_path` drives into `data_ram` (ce/we/addr/sel/data). It decodes a 16-byte window and provides a prescaled 32-bit up-counter, a compare register with sticky match/overflow flags, optional auto-reload, and a level interrupt. The top level muxes read data between `data_ram` and this block using `hit_o`.

## Interface

**Parameters**
- `BASE_ADDR`, default `32'h1000_0000`: window base; decode is `addr[31:4] == BASE_ADDR[31:4]`.

**Ports**
- `clk` (in, 1): single clock; all state changes on its rising edge.
- `rst` (in, 1): asynchronous, active-low reset.
- `ce` (in, 1): bus access enable.
- `we` (in, 1): 1 = write, 0 = read.
- `addr` (in, 32): byte address; `[3:2]` selects the register, `[1:0]` is ignored.
- `sel` (in, 4): byte-lane write enables; `sel[i]` covers `data_i[8i+7:8i]`.
- `data_i` (in, 32): write data.
- `data_o` (out, 32): read data (combinational).
- `hit_o` (out, 1): `ce & address-in-window`.
- `irq_o` (out, 1): level interrupt, registered.

## Operation

**Registers** (offset: name, fields)
- `0x0` CTRL
  - `[0]` EN: count enable.
  - `[1]` RELOAD: on match, COUNT reloads to 0.
  - `[2]` IRQEN.
  - `[15:8]` PRESC.
  - All other bits read 0 and ignore writes.
- `0x4` COUNT: 32-bit, read/write.
- `0x8` COMPARE: 32-bit, read/write.
- `0xC` STATUS
  - `[0]` MATCH and `[1]` OVF: sticky, write-1-to-clear per bit (byte lane 0 only).
  - Other bits read 0.

**Reset values**
- CTRL, COUNT, STATUS, internal prescaler count: 0.
- COMPARE: `32'hFFFF_FFFF`.
- `irq_o`: 0.
- `data_o`: 0 when idle.

**Writes**
- Occur when `ce & we & hit`.
- Each register byte is updated only where `sel` is set.
- Writes with `ce=0`, or outside the window, have no effect.

**Reads**
- `data_o` = selected register when `ce & ~we & hit`, else 0.
- Reads have no side effects.

**Prescaler**
- 8-bit `pcnt`. While EN=1: `pcnt` counts 0..PRESC, then wraps to 0.
- `tick = EN & (pcnt == PRESC)`, so PRESC=0 gives a tick every cycle.
- While EN=0: `pcnt` holds at 0.
- Any write to CTRL clears `pcnt`.

**Count update on tick**, using the pre-edge COUNT value:
- If COUNT == COMPARE: set MATCH. COUNT becomes 0 if RELOAD, else COUNT+1.
- Else if COUNT == `32'hFFFF_FFFF`: COUNT wraps to 0 and OVF is set.
- Else: COUNT+1.
- When both apply (COMPARE = `FFFF_FFFF`, no RELOAD), MATCH and OVF set together.

**Interrupt**
- `irq_o <= IRQEN & (MATCH | OVF)`, using next-state values (registered, one edge after the flag or IRQEN changes).

**Simultaneous events**
- A bus write to COUNT in the same cycle as a tick: the written bytes win; unwritten bytes take the tick result. Match/overflow evaluation still uses the pre-edge value.
- W1C of a flag in the same cycle that the flag is set by hardware: the set wins.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); counting resumes only after software sets EN.

## Timing
- Read latency: 0 cycles. `data_o` and `hit_o` are combinational from the bus inputs, matching `data_ram` read behaviour.
- Write latency: the register is visible on reads in the cycle after the write edge.
- Tick period: PRESC+1 cycles. The first tick after an EN 0→1 write occurs PRESC cycles after that write edge.
- MATCH visible in STATUS one edge after the tick with COUNT==COMPARE. `irq_o` rises on that same edge.
- No stalls and no wait states: every access completes in its cycle.

## Test plan
1. **Reset.**
   - Stimulus: hold `rst=0`, release, read all four offsets.
   - Required: reads return 0, 0, `FFFF_FFFF`, 0; `irq_o=0`.
2. **Compare match with interrupt.**
   - Stimulus: write COMPARE=3, then CTRL=`0x0005` (EN, IRQEN, PRESC=0).
   - Required: COUNT reads 1, 2, 3, 4 on successive cycles; STATUS=1 and `irq_o=1` from the edge where COUNT goes 3→4.
   - Then write STATUS=1: `irq_o=0` next cycle.
3. **Auto-reload with prescaler.**
   - Stimulus: COMPARE=2, CTRL=`0x0203` (EN, RELOAD, PRESC=2).
   - Required: COUNT changes every 3 cycles through the sequence 0,1,2,0,1,2; MATCH is set at the first 2→0 transition.
4. **Overflow.**
   - Stimulus: write COUNT=`FFFF_FFFE`, COMPARE=0, CTRL=1.
   - Required: after 2 ticks COUNT=0 and STATUS=`0x2`; `irq_o` stays 0 (IRQEN=0).
5. **Byte lanes and decode.**
   - Stimulus: write COMPARE with `sel=4'b0010`, `data_i=AABBCCDD`.
   - Required: COMPARE reads `FFFF_CCFF`.
   - Stimulus: write to `BASE+0x10`, or with `ce=0`.
   - Required: no register change, `hit_o=0`, `data_o=0`.
6. **Collisions.**
   - Stimulus: a COUNT write of 100 lands on a tick edge.
   - Required: COUNT=100 afterwards.
   - Stimulus: a W1C of MATCH lands on a match edge.
   - Required: MATCH remains 1.
   - Stimulus: async `rst` pulse mid-count.
   - Required: all registers return to reset values without waiting for a clock edge.
